// File: rtl/mpif_fifo_rd_stage.sv
// Read-side stage of the MPIF FIFO: issues RAM reads, buffers up to two words for the
// consumer, and sequences FIFO flushes with a minimum settle time.
module mpif_fifo_rd_stage #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned FLUSH_MIN = 8
) (
    input  logic                 rdClk,
    input  logic                 rdHardReset_n,
    input  logic                 rdEnable,
    input  logic                 flushReq,
    input  logic                 fifoEmpty,
    input  logic                 fifoPtrsNull,
    input  logic [DATAWIDTH-1:0] fifoRdData,
    input  logic                 outReady,
    output logic                 fifoRead,
    output logic                 rdFlush,
    output logic [DATAWIDTH-1:0] outData,
    output logic                 outValid,
    output logic                 flushDone,
    output logic                 busy,
    output logic [15:0]          wordCnt
);

    localparam int unsigned WaitW = $clog2(FLUSH_MIN + 2);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(FLUSH_MIN);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StFlushReq,
        StFlushWait
    } state_e;

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] buf0_q, buf0_d;
    logic [DATAWIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]           bcnt_q, bcnt_d;
    logic                 inflight_q, inflight_d;
    logic [WaitW-1:0]     wait_q, wait_d;
    logic [15:0]          cnt_q, cnt_d;

    logic [1:0] occ;
    logic       pop;
    logic       flush_enter;
    logic       wait_done;

    // occ counts buffered words plus the read whose data lands next cycle
    assign occ         = bcnt_q + {1'b0, inflight_q};
    assign outValid    = (bcnt_q != 2'd0);
    assign pop         = outValid & outReady;
    assign flush_enter = flushReq &
                         ((state_q == StIdle) | (state_q == StRun) | (state_q == StDrain));
    assign wait_done   = (state_q == StFlushWait) & (wait_q >= WaitMax) & fifoPtrsNull;

    assign fifoRead  = (state_q == StRun) & ~fifoEmpty & ((occ - {1'b0, pop}) < 2'd2);
    assign rdFlush   = (state_q == StFlushReq);
    assign flushDone = wait_done;
    assign busy      = (state_q != StIdle);
    assign outData   = buf0_q;
    assign wordCnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        if (flush_enter) begin
            state_d = StFlushReq;
        end else begin
            case (state_q)
                StIdle:      if (rdEnable) state_d = StRun;
                StRun:       if (!rdEnable) state_d = StDrain;
                StDrain: begin
                    if (rdEnable)          state_d = StRun;
                    else if (occ == 2'd0)  state_d = StIdle;
                end
                StFlushReq:  state_d = StFlushWait;
                StFlushWait: if (wait_done) state_d = rdEnable ? StRun : StIdle;
                default:     state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        bcnt_d     = bcnt_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        // a read issued in the flush-request cycle must not land in the buffer
        inflight_d = fifoRead & ~flush_enter;
        if (flush_enter) begin
            buf0_d = '0;
            buf1_d = '0;
            bcnt_d = 2'd0;
            cnt_d  = 16'd0;
            wait_d = '0;
        end else begin
            if (pop) cnt_d = cnt_q + 16'd1;
            case ({inflight_q, pop})
                2'b01: begin
                    buf0_d = buf1_q;
                    bcnt_d = bcnt_q - 2'd1;
                end
                2'b10: begin
                    if (bcnt_q == 2'd0) buf0_d = fifoRdData;
                    else                buf1_d = fifoRdData;
                    bcnt_d = bcnt_q + 2'd1;
                end
                2'b11: begin
                    if (bcnt_q == 2'd1) begin
                        buf0_d = fifoRdData;
                    end else begin
                        buf0_d = buf1_q;
                        buf1_d = fifoRdData;
                    end
                end
                default: ;
            endcase
            if (state_q != StFlushWait)  wait_d = '0;
            else if (wait_q < WaitMax)   wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge rdClk or negedge rdHardReset_n) begin
        if (!rdHardReset_n) begin
            state_q    <= StIdle;
            buf0_q     <= '0;
            buf1_q     <= '0;
            bcnt_q     <= 2'd0;
            inflight_q <= 1'b0;
            wait_q     <= '0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            bcnt_q     <= bcnt_d;
            inflight_q <= inflight_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mpif_fifo_rd_stage.sv
// Bench for mpif_fifo_rd_stage: FIFO/RAM model, scoreboard of delivered words, a
// cycle-vector table for streaming and hand-written sequences for the corner cases.
module tb_mpif_fifo_rd_stage;

    localparam int unsigned DW   = 32;
    localparam int unsigned FMIN = 8;

    logic          rdClk;
    logic          rdHardReset_n;
    logic          rdEnable;
    logic          flushReq;
    logic          fifoEmpty;
    logic          fifoPtrsNull;
    logic [DW-1:0] fifoRdData;
    logic          outReady;
    logic          fifoRead;
    logic          rdFlush;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          flushDone;
    logic          busy;
    logic [15:0]   wordCnt;

    mpif_fifo_rd_stage #(
        .DATAWIDTH (DW),
        .FLUSH_MIN (FMIN)
    ) dut (
        .rdClk         (rdClk),
        .rdHardReset_n (rdHardReset_n),
        .rdEnable      (rdEnable),
        .flushReq      (flushReq),
        .fifoEmpty     (fifoEmpty),
        .fifoPtrsNull  (fifoPtrsNull),
        .fifoRdData    (fifoRdData),
        .outReady      (outReady),
        .fifoRead      (fifoRead),
        .rdFlush       (rdFlush),
        .outData       (outData),
        .outValid      (outValid),
        .flushDone     (flushDone),
        .busy          (busy),
        .wordCnt       (wordCnt)
    );

    initial begin
        rdClk = 1'b0;
        forever #5 rdClk = ~rdClk;
    end

    // FIFO + RAM model; in source mode the data is the read pointer itself
    logic [DW-1:0] mem [256];
    logic [31:0]   wr_ptr = 32'd0;
    logic [31:0]   rd_ptr;
    logic          src_inf = 1'b0;

    assign fifoEmpty = (rd_ptr == wr_ptr);

    always @(posedge rdClk or negedge rdHardReset_n) begin
        if (!rdHardReset_n) begin
            rd_ptr     <= wr_ptr;
            fifoRdData <= '0;
        end else if (rdFlush) begin
            rd_ptr <= wr_ptr;
        end else if (fifoRead) begin
            fifoRdData <= src_inf ? rd_ptr : mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 32'd1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr = wr_ptr + 32'd1;
        sb.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge rdClk);
        rdHardReset_n = 1'b0;
        repeat (2) @(negedge rdClk);
        sb.delete();
        rdHardReset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fifoRead"}, 32'(fifoRead), 32'd0);
        chk({tag, "_rdFlush"}, 32'(rdFlush), 32'd0);
        chk({tag, "_outValid"}, 32'(outValid), 32'd0);
        chk({tag, "_flushDone"}, 32'(flushDone), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_outData"}, 32'(outData), 32'd0);
        chk({tag, "_wordCnt"}, 32'(wordCnt), 32'd0);
    endtask

    // Scoreboard monitor: a pop happens at the next rising edge
    initial begin
        forever begin
            @(negedge rdClk);
            #2;
            if (rdHardReset_n && outValid && outReady && !src_inf) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_word", 32'(outData), 32'hdead_beef);
                end else begin
                    chk("sb_data", 32'(outData), 32'(sb.pop_front()));
                end
            end
        end
    end

    typedef struct {
        logic        rd_en;
        logic        rdy;
        logic        exp_rd;
        logic        exp_ov;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n;
        int t0;
        bit seen;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 16'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h12, 16'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 16'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 16'd3};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h15, 16'd4};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 16'd5};

        rdHardReset_n = 1'b0;
        rdEnable      = 1'b0;
        flushReq      = 1'b0;
        fifoPtrsNull  = 1'b0;
        outReady      = 1'b0;
        #1;
        chk_all_zero("reset");
        do_reset();

        // Streaming, cycle by cycle
        for (int i = 0; i < 5; i++) push_word(32'h11 + 32'(i));
        for (int i = 0; i < 9; i++) begin
            @(negedge rdClk);
            rdEnable = tbl[i].rd_en;
            outReady = tbl[i].rdy;
            #1;
            chk($sformatf("stream%0d_fifoRead", i), 32'(fifoRead), 32'(tbl[i].exp_rd));
            chk($sformatf("stream%0d_outValid", i), 32'(outValid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov)
                chk($sformatf("stream%0d_outData", i), 32'(outData), tbl[i].exp_data);
            chk($sformatf("stream%0d_wordCnt", i), 32'(wordCnt), 32'(tbl[i].exp_cnt));
        end

        // Backpressure: four words queued, consumer stalled
        @(negedge rdClk);
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h21 + 32'(i));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (fifoRead) n++;
            @(negedge rdClk);
        end
        #1;
        chk("bp_read_pulses", 32'(n), 32'd2);
        chk("bp_outValid", 32'(outValid), 32'd1);
        chk("bp_outData_held", 32'(outData), 32'h21);
        outReady = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge rdClk);
            #3;
            if (sb.size() == 0) seen = 1'b1;
        end
        chk("bp_all_delivered", 32'(seen), 32'd1);
        @(negedge rdClk);
        #1;
        chk("bp_wordCnt", 32'(wordCnt), 32'd9);

        // Drain with two words buffered and two left in the FIFO
        outReady = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h31 + 32'(i));
        repeat (6) @(negedge rdClk);
        rdEnable = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (fifoRead) n++;
            @(negedge rdClk);
            outReady = 1'b1;
        end
        #1;
        chk("drain_no_reads", 32'(n), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_wordCnt", 32'(wordCnt), 32'd11);
        chk("drain_fifo_left", 32'(wr_ptr - rd_ptr), 32'd2);

        // Flush with occ == 2
        outReady = 1'b0;
        rdEnable = 1'b1;
        repeat (5) @(negedge rdClk);
        #1;
        chk("fl_pre_outValid", 32'(outValid), 32'd1);
        chk("fl_pre_outData", 32'(outData), 32'h33);
        @(negedge rdClk);
        flushReq = 1'b1;
        #1;
        chk("fl_req_cycle_rdFlush", 32'(rdFlush), 32'd0);
        @(negedge rdClk);
        flushReq = 1'b0;
        rdEnable = 1'b0;
        sb.delete();
        #1;
        chk("fl_rdFlush", 32'(rdFlush), 32'd1);
        chk("fl_outValid", 32'(outValid), 32'd0);
        chk("fl_wordCnt", 32'(wordCnt), 32'd0);
        chk("fl_busy", 32'(busy), 32'd1);
        t0 = 0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge rdClk);
            #1;
            t0++;
            if (rdFlush || flushDone || fifoRead || outValid) n++;
        end
        chk("fl_wait_quiet", 32'(n), 32'd0);
        fifoPtrsNull = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            #1;
            if (flushDone) seen = 1'b1;
            else begin
                @(negedge rdClk);
                t0++;
            end
        end
        chk("fl_done_seen", 32'(seen), 32'd1);
        chk("fl_min_wait", 32'(t0 >= int'(FMIN)), 32'd1);
        @(negedge rdClk);
        #1;
        chk("fl_done_single", 32'(flushDone), 32'd0);
        chk("fl_idle_busy", 32'(busy), 32'd0);

        // Reset while in FLUSH_WAIT
        fifoPtrsNull = 1'b0;
        @(negedge rdClk);
        flushReq = 1'b1;
        @(negedge rdClk);
        flushReq = 1'b0;
        repeat (3) @(negedge rdClk);
        fifoPtrsNull = 1'b1;
        #2;
        rdHardReset_n = 1'b0;
        #1;
        chk_all_zero("rst_fw");
        @(negedge rdClk);
        rdHardReset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge rdClk);
            #1;
            if (flushDone || busy) n++;
        end
        chk("rst_fw_no_done", 32'(n), 32'd0);

        // First read is the cycle after rdEnable is sampled
        push_word(32'h41);
        @(negedge rdClk);
        rdEnable = 1'b1;
        outReady = 1'b1;
        #1;
        chk("first_rd_idle", 32'(fifoRead), 32'd0);
        @(negedge rdClk);
        #1;
        chk("first_rd_run", 32'(fifoRead), 32'd1);
        repeat (4) @(negedge rdClk);
        chk("first_rd_delivered", 32'(sb.size()), 32'd0);

        // wordCnt wrap over 65537 words
        rdEnable = 1'b0;
        do_reset();
        #1;
        chk_all_zero("rst2");
        src_inf  = 1'b1;
        wr_ptr   = wr_ptr + 32'd65537;
        rdEnable = 1'b1;
        outReady = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 70000 && !seen; i++) begin
            @(negedge rdClk);
            #1;
            if (fifoEmpty) seen = 1'b1;
        end
        chk("wrap_source_drained", 32'(seen), 32'd1);
        repeat (4) @(negedge rdClk);
        #1;
        chk("wrap_wordCnt", 32'(wordCnt), 32'd1);
        chk("wrap_outValid", 32'(outValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpif_fifo_rd_stage.md
MPIF_FIFO_RD_STAGE -- requirements
Module: mpif_fifo_rd_stage

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, FIFO word and output data width.
REQ-002 SHALL have parameter FLUSH_MIN, default 8, minimum rdClk cycles spent in FLUSH_WAIT.
REQ-003 SHALL have port rdClk  input  1  read-domain clock.
REQ-004 SHALL have port rdHardReset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rdEnable  input  1  level; permits new FIFO reads.
REQ-006 SHALL have port flushReq  input  1  single-cycle flush request.
REQ-007 SHALL have port fifoEmpty  input  1  FIFO empty status from the FIFO controller.
REQ-008 SHALL have port fifoPtrsNull  input  1  both FIFO pointers are zero.
REQ-009 SHALL have port fifoRdData  input  DATAWIDTH  RAM read data, valid one cycle after fifoRead.
REQ-010 SHALL have port outReady  input  1  consumer accepts data.
REQ-011 SHALL have port fifoRead  output  1  read enable to the FIFO controller.
REQ-012 SHALL have port rdFlush  output  1  flush pulse to the FIFO controller.
REQ-013 SHALL have port outData  output  DATAWIDTH  head word.
REQ-014 SHALL have port outValid  output  1  outData valid.
REQ-015 SHALL have port flushDone  output  1  one-cycle pulse when the flush completes.
REQ-016 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-017 SHALL have port wordCnt  output  16  count of delivered words.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN, FLUSH_REQ and FLUSH_WAIT.
REQ-019 State transitions SHALL be:
- IDLE->RUN when rdEnable=1.
- RUN->DRAIN when rdEnable=0.
- DRAIN->IDLE when occ=0.
- DRAIN->RUN when rdEnable=1.
REQ-020 flushReq=1 in IDLE, RUN or DRAIN SHALL force FLUSH_REQ next cycle, with priority over all other transitions; flushReq SHALL be ignored in FLUSH_REQ and FLUSH_WAIT.
REQ-021 The block SHALL hold a 2-entry output buffer, plus an occupancy counter occ (0..2) equal to buffered words plus in-flight reads.
REQ-022 fifoRead SHALL equal (state==RUN) & !fifoEmpty & ((occ - pop) < 2), where pop = outValid & outReady.
REQ-023 fifoRdData SHALL be captured into the buffer at the end of the cycle after fifoRead=1.
- Read-to-outValid latency: fifoRead in cycle N gives outValid in cycle N+2.
REQ-024 outValid SHALL be 1 iff the buffer is non-empty; outData SHALL be the oldest entry.
- Buffer order is FIFO.
- outData SHALL be stable while outValid=1 and outReady=0.
REQ-025 With outReady=1 continuously and the FIFO non-empty, the block SHALL sustain one word per cycle.
REQ-026 Simultaneous capture and pop SHALL leave occupancy unchanged, with no data loss or duplication.
REQ-027 occ SHALL never exceed 2; fifoRead SHALL never assert when occ - pop = 2.
REQ-028 In DRAIN, no new reads SHALL be issued; buffered and in-flight words SHALL still be delivered.
REQ-029 FLUSH_REQ SHALL last exactly 1 cycle and assert rdFlush=1 for that cycle only, then move to FLUSH_WAIT.
REQ-030 On entering FLUSH_REQ the following SHALL happen:
- buffer and occ cleared;
- in-flight read data discarded;
- wordCnt cleared;
- outValid=0 from that cycle.
REQ-031 In FLUSH_WAIT, fifoRead, rdFlush and outValid SHALL be 0, and a wait counter SHALL increment.
REQ-032 FLUSH_WAIT SHALL exit when the wait counter >= FLUSH_MIN and fifoPtrsNull=1.
- On exit, flushDone pulses for 1 cycle.
- Next state is RUN if rdEnable=1, otherwise IDLE.
REQ-033 wordCnt SHALL increment by 1 per pop and wrap from 0xFFFF to 0x0000.

Reset
REQ-034 On rdHardReset_n=0 the block SHALL asynchronously clear the following:
- state to IDLE;
- occ, buffer and wait counter to 0;
- fifoRead, rdFlush, outValid, flushDone and busy to 0;
- outData to 0;
- wordCnt to 0x0000.
REQ-035 Reset asserted mid-read or mid-flush SHALL abort the operation with no pulse on flushDone after release.
REQ-036 The first possible fifoRead after reset release SHALL be the cycle after rdEnable=1 is sampled.

Verification
REQ-037 Streaming: preload 5 words 0x11..0x15, rdEnable=1, outReady=1 -> the block SHALL show the following:
- 0x11..0x15 on consecutive cycles;
- wordCnt=5;
- fifoRead deasserts when fifoEmpty=1.
REQ-038 Backpressure: outReady=0 with 4 words queued -> the block SHALL show the following:
- exactly 2 fifoRead pulses;
- outData held at the first word;
- release outReady -> all 4 words delivered in order.
REQ-039 Flush mid-stream: flushReq while occ=2 -> the block SHALL show the following:
- rdFlush high for 1 cycle;
- outValid=0 and wordCnt=0 next cycle;
- flushDone once, after >= FLUSH_MIN cycles, with fifoPtrsNull=1.
REQ-040 Drain: clear rdEnable with 2 words buffered -> the block SHALL show the following:
- no further fifoRead;
- both words delivered;
- state returns to IDLE with busy=0.
REQ-041 Wrap: 65537 words delivered -> wordCnt=0x0001.
REQ-042 Reset in FLUSH_WAIT -> all outputs 0; no flushDone after release.
